// File: rtl/seq_scan_if.sv
// Handshake/config bundle for the serial scan controller.
// master: drives config/start/data; slave: returns busy/done/hit/ser_bit/match_cnt.
interface seq_scan_if #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
);
    logic              cfg_we;
    logic [PAT_W-1:0]  cfg_pat;
    logic              cfg_ovl;
    logic              start;
    logic [WORD_W-1:0] data_in;
    logic              busy;
    logic              done;
    logic              hit;
    logic              ser_bit;
    logic [CNT_W-1:0]  match_cnt;

    modport master (
        output cfg_we, cfg_pat, cfg_ovl, start, data_in,
        input  busy, done, hit, ser_bit, match_cnt
    );

    modport slave (
        input  cfg_we, cfg_pat, cfg_ovl, start, data_in,
        output busy, done, hit, ser_bit, match_cnt
    );
endinterface

// File: rtl/seq_scan_ctrl.sv
// Serial scan controller: shifts a start-latched word MSB-first through a
// programmable PAT_W-bit pattern window and counts matches.
// Ports: clk, reset (async, active-high), bus (seq_scan_if.slave):
//   cfg_we/cfg_pat/cfg_ovl config, start/data_in scan request,
//   busy/done/hit/ser_bit/match_cnt status.
module seq_scan_ctrl #(
    parameter int WORD_W = 16,
    parameter int PAT_W  = 4,
    parameter int CNT_W  = 5
) (
    input  logic       clk,
    input  logic       reset,
    seq_scan_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    localparam int FILL_W = $clog2(PAT_W + 1);
    localparam int BCNT_W = $clog2(WORD_W);

    localparam logic [FILL_W-1:0] FILL_FULL = FILL_W'(PAT_W);
    localparam logic [BCNT_W-1:0] BCNT_LAST = BCNT_W'(WORD_W - 1);
    // Power-on pattern is the classic 1010 detector.
    localparam logic [PAT_W-1:0]  PAT_RST   = PAT_W'(4'b1010);

    state_t              state_q;
    logic [WORD_W-1:0]   shreg_q;
    logic [PAT_W-1:0]    win_q;
    logic [FILL_W-1:0]   fill_q;
    logic [BCNT_W-1:0]   bitcnt_q;
    logic [PAT_W-1:0]    pat_q;
    logic                ovl_q;
    logic [CNT_W-1:0]    cnt_q;
    logic                busy_q;
    logic                done_q;
    logic                hit_q;

    logic                ser_bit;
    logic [PAT_W-1:0]    win_d;
    logic [FILL_W-1:0]   fill_d;
    logic [CNT_W-1:0]    cnt_d;
    logic                match;

    // Scanned bit is taken straight from the shift register MSB.
    assign ser_bit = (state_q == S_SHIFT) && shreg_q[WORD_W-1];

    // Match is judged on the window as it will be after this edge.
    always_comb begin
        win_d  = {win_q[PAT_W-2:0], ser_bit};
        fill_d = (fill_q == FILL_FULL) ? fill_q : fill_q + 1'b1;
        match  = (fill_d == FILL_FULL) && (win_d == pat_q);
        cnt_d  = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            shreg_q  <= '0;
            win_q    <= '0;
            fill_q   <= '0;
            bitcnt_q <= '0;
            pat_q    <= PAT_RST;
            ovl_q    <= 1'b1;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            hit_q    <= 1'b0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    hit_q  <= 1'b0;
                    // Config lands on the same edge as start, so the
                    // scan that starts here already sees it.
                    if (bus.cfg_we) begin
                        pat_q <= bus.cfg_pat;
                        ovl_q <= bus.cfg_ovl;
                    end
                    if (bus.start) begin
                        shreg_q  <= bus.data_in;
                        cnt_q    <= '0;
                        win_q    <= '0;
                        fill_q   <= '0;
                        bitcnt_q <= '0;
                        busy_q   <= 1'b1;
                        state_q  <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    shreg_q  <= shreg_q << 1;
                    win_q    <= win_d;
                    bitcnt_q <= bitcnt_q + 1'b1;
                    hit_q    <= match;
                    if (match) begin
                        cnt_q  <= cnt_d;
                        // Non-overlap mode demands PAT_W fresh bits.
                        fill_q <= ovl_q ? fill_d : '0;
                    end else begin
                        fill_q <= fill_d;
                    end
                    if (bitcnt_q == BCNT_LAST) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    hit_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    hit_q   <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.hit       = hit_q;
    assign bus.ser_bit   = ser_bit;
    assign bus.match_cnt = cnt_q;
endmodule
